// File: rtl/adc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_pkg : shared state encoding and default sizes for the SAR scan  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package adc_pkg;

    localparam int DEF_RES        = 12;
    localparam int DEF_NCH        = 4;
    localparam int DEF_SAMPLE_CYC = 2;
    localparam int DEF_OSR_MAX    = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAMPLE  = 3'd1,
        CONVERT = 3'd2,
        ACCUM   = 3'd3,
        NEXT_CH = 3'd4
    } adc_state_t;

endpackage
`default_nettype wire

// File: rtl/adc_sar_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_sar_reg : successive-approximation bit-decision register that   |
// | walks a probe bit MSB to LSB and produces the trial DAC code        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module adc_sar_reg
    import adc_pkg::*;
#(
    parameter int RES = DEF_RES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic           comp,
    output logic [RES-1:0] trial_code,
    output logic [RES-1:0] code,
    output logic           last_bit
);

    logic [RES-1:0] decided;
    logic [RES-1:0] probe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decided <= '0;
            probe   <= '0;
        end else if (load) begin
            decided <= '0;
            probe   <= {1'b1, {(RES-1){1'b0}}};
        end else if (step) begin
            if (comp) begin
                decided <= decided | probe;
            end
            probe <= probe >> 1;
        end
    end

    // Probe reaches zero after the LSB decision, so the code holds steady afterwards.
    assign trial_code = decided | probe;
    assign code       = decided;
    assign last_bit   = probe[0];

endmodule
`default_nettype wire

// File: rtl/adc_sar_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adc_sar_scan_ctrl : multi-channel SAR ADC scan sequencer with       |
// | oversampling average and a valid/ready result port                  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module adc_sar_scan_ctrl
    import adc_pkg::*;
#(
    parameter int RES        = DEF_RES,
    parameter int NCH        = DEF_NCH,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int OSR_MAX    = DEF_OSR_MAX
) (
    input  logic                                 clk_vcm,
    input  logic                                 rst_n,
    input  logic                                 start_conversion_in,
    input  logic [NCH-1:0]                       channel_mask_in,
    input  logic [$clog2(OSR_MAX+1)-1:0]         osr_log2_in,
    input  logic                                 continuous_in,
    input  logic                                 comparator_in,
    output logic                                 sample_out,
    output logic [RES-1:0]                       dac_code_out,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] channel_sel_out,
    output logic [RES-1:0]                       result_out,
    output logic [(NCH > 1 ? $clog2(NCH) : 1)-1:0] result_channel_out,
    output logic                                 result_valid_out,
    input  logic                                 result_ready_in,
    output logic                                 conversion_finished_out,
    output logic                                 busy_out,
    output logic                                 overrun_out
);

    localparam int OSRW = $clog2(OSR_MAX + 1);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int ACCW = RES + OSR_MAX;
    localparam int CNTW = OSR_MAX + 1;
    localparam int SCW  = 4;

    adc_state_t      state;
    adc_state_t      next_state;

    logic [NCH-1:0]  mask_q;
    logic [OSRW-1:0] osr_q;
    logic [OSRW-1:0] osr_clamped;
    logic [CHW-1:0]  cur_ch;
    logic [ACCW-1:0] accum;
    logic [CNTW-1:0] conv_cnt;
    logic [SCW-1:0]  sample_cnt;

    logic            start_accept;
    logic            sample_last;
    logic            conv_last;
    logic            next_found;
    logic [CHW-1:0]  next_idx;
    logic [CHW-1:0]  low_idx;
    logic [CHW-1:0]  start_idx;

    logic [RES-1:0]  trial_code;
    logic [RES-1:0]  sar_code;
    logic            last_bit;

    adc_sar_reg #(
        .RES (RES)
    ) u_sar (
        .clk        (clk_vcm),
        .rst_n      (rst_n),
        .load       (state == SAMPLE),
        .step       (state == CONVERT),
        .comp       (comparator_in),
        .trial_code (trial_code),
        .code       (sar_code),
        .last_bit   (last_bit)
    );

    assign osr_clamped  = (osr_log2_in > OSRW'(OSR_MAX)) ? OSRW'(OSR_MAX) : osr_log2_in;
    assign start_accept = (state == IDLE) && start_conversion_in && (|channel_mask_in);
    assign sample_last  = (sample_cnt == SCW'(SAMPLE_CYC - 1));
    assign conv_last    = (conv_cnt == ((CNTW'(1) << osr_q) - CNTW'(1)));
    assign channel_sel_out = cur_ch;

    // Descending scans leave the lowest qualifying index in each result.
    always_comb begin
        next_found = 1'b0;
        next_idx   = '0;
        low_idx    = '0;
        start_idx  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = CHW'(i);
                if (i > int'(cur_ch)) begin
                    next_found = 1'b1;
                    next_idx   = CHW'(i);
                end
            end
            if (channel_mask_in[i]) begin
                start_idx = CHW'(i);
            end
        end
    end

    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state              = state;
        sample_out              = 1'b0;
        dac_code_out            = '0;
        busy_out                = 1'b1;
        conversion_finished_out = 1'b0;
        case (state)
            IDLE: begin
                busy_out = 1'b0;
                if (start_accept) begin
                    next_state = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_out = 1'b1;
                if (sample_last) begin
                    next_state = CONVERT;
                end
            end
            CONVERT: begin
                dac_code_out = trial_code;
                if (last_bit) begin
                    next_state = ACCUM;
                end
            end
            ACCUM: begin
                next_state = conv_last ? NEXT_CH : SAMPLE;
            end
            NEXT_CH: begin
                conversion_finished_out = !next_found;
                next_state = (next_found || continuous_in) ? SAMPLE : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            osr_q      <= '0;
            cur_ch     <= '0;
            accum      <= '0;
            conv_cnt   <= '0;
            sample_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_accept) begin
                        mask_q     <= channel_mask_in;
                        osr_q      <= osr_clamped;
                        cur_ch     <= start_idx;
                        accum      <= '0;
                        conv_cnt   <= '0;
                        sample_cnt <= '0;
                    end
                end
                SAMPLE: begin
                    sample_cnt <= sample_last ? '0 : sample_cnt + SCW'(1);
                end
                ACCUM: begin
                    accum    <= accum + ACCW'(sar_code);
                    conv_cnt <= conv_cnt + CNTW'(1);
                end
                NEXT_CH: begin
                    accum    <= '0;
                    conv_cnt <= '0;
                    cur_ch   <= next_found ? next_idx : low_idx;
                end
                default: begin
                end
            endcase
        end
    end

    // A new result always wins over a same-cycle handshake; losing an unread one is flagged.
    always_ff @(posedge clk_vcm or negedge rst_n) begin
        if (!rst_n) begin
            result_out         <= '0;
            result_channel_out <= '0;
            result_valid_out   <= 1'b0;
            overrun_out        <= 1'b0;
        end else if (state == NEXT_CH) begin
            result_out         <= RES'(accum >> osr_q);
            result_channel_out <= cur_ch;
            result_valid_out   <= 1'b1;
            if (result_valid_out && !result_ready_in) begin
                overrun_out <= 1'b1;
            end
        end else begin
            if (result_valid_out && result_ready_in) begin
                result_valid_out <= 1'b0;
            end
            if (start_accept) begin
                overrun_out <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/adc_sar_scan_ctrl.md
ADC_SAR_SCAN_CTRL -- requirements
Module: adc_sar_scan_ctrl

Interface
REQ-001 Parameters SHALL be: RES, default 12, SAR resolution in bits (4..16); NCH, default 4, analog channel count (1..16); SAMPLE_CYC, default 2, sample-phase length in cycles (1..15); OSR_MAX, default 4, maximum log2 oversampling ratio.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset, on these ports: clk_vcm in 1, conversion clock (rising edge); rst_n in 1, asynchronous active-low reset.
REQ-003 start_conversion_in in 1, starts a scan when sampled high in IDLE.
REQ-004 channel_mask_in in NCH, channels included in the scan; latched at start.
REQ-005 osr_log2_in in clog2(OSR_MAX+1), log2 of conversions averaged per channel; latched at start; values above OSR_MAX clamp to OSR_MAX.
REQ-006 continuous_in in 1, restart the scan after the last channel.
REQ-007 comparator_in in 1, analog comparator decision: 1 means input >= DAC.
REQ-008 sample_out out 1, sample switch closed.
REQ-009 dac_code_out out RES, trial code to the capacitive DAC.
REQ-010 channel_sel_out out max(1,clog2(NCH)), analog mux select.
REQ-011 result_out out RES, averaged result.
REQ-012 result_channel_out out max(1,clog2(NCH)), channel of result_out.
REQ-013 result_valid_out out 1, result held until accepted.
REQ-014 result_ready_in in 1, consumer accepts the result.
REQ-015 conversion_finished_out out 1, one-cycle pulse when a scan completes.
REQ-016 busy_out out 1, high in every state except IDLE.
REQ-017 overrun_out out 1, sticky flag: an unaccepted result was overwritten.

Function
REQ-018 The FSM SHALL have the states IDLE, SAMPLE, CONVERT, ACCUM and NEXT_CH.
REQ-019 IDLE: when start_conversion_in=1 and the latched mask is nonzero, the FSM SHALL latch its config, clear overrun_out, select the lowest set mask bit and go to SAMPLE; a zero mask SHALL keep the FSM in IDLE.
REQ-020 SAMPLE: sample_out SHALL be 1 for exactly SAMPLE_CYC cycles, then the FSM SHALL go to CONVERT.
REQ-021 CONVERT SHALL last exactly RES cycles. Cycle k (k=0 MSB first) SHALL drive dac_code_out as the decided bits so far with bit RES-1-k set. comparator_in SHALL be sampled at the end of each cycle; 1 keeps the bit, 0 clears it.
REQ-022 ACCUM (1 cycle) SHALL add the code to a RES+OSR_MAX-bit accumulator. If fewer than 2^osr conversions have completed, the FSM SHALL return to SAMPLE; otherwise it SHALL go to NEXT_CH.
REQ-023 NEXT_CH (1 cycle) SHALL register result_out = accumulator >> osr (truncating), set result_valid_out and result_channel_out, and clear the accumulator.
REQ-024 From NEXT_CH the FSM SHALL go to SAMPLE on the next set mask bit above the current channel. After the highest set bit: if continuous_in=1 it SHALL wrap to the lowest set bit; otherwise it SHALL go to IDLE. conversion_finished_out SHALL pulse during that NEXT_CH cycle.
REQ-025 With osr=0, result_valid_out SHALL rise SAMPLE_CYC+RES+2 cycles after the start cycle.
REQ-026 result_valid_out SHALL clear on the cycle after valid&&ready, unless a new result is written in that same cycle, in which case the new result wins and valid stays 1.
REQ-027 If a new result is written while valid=1 and ready=0, the old result SHALL be overwritten and overrun_out set.
REQ-028 start_conversion_in SHALL be ignored while busy_out=1. Deasserting continuous_in SHALL take effect only at the end of the current scan.
REQ-029 Outside SAMPLE and CONVERT, dac_code_out SHALL be 0 and sample_out 0.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, zero all outputs, and clear the accumulator, counters, latched config and overrun_out.
REQ-031 A reset asserted mid-conversion SHALL discard the partial result and produce no pulse on release.

Structure
REQ-032 A shared package adc_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 The bit-decision register and trial-code generation SHALL be one sub-module, adc_sar_reg.

Verification
REQ-034 The bench SHALL use RES=8, NCH=4, SAMPLE_CYC=2 with a comparator model comparator_in = (vin[ch] >= dac_code_out).
REQ-035 vin[0]=0xA5, mask=0001, osr=0, start -> result 0xA5, ch 0, valid at cycle 12, one finished pulse.
REQ-036 vin={0x00,0xFF,0x80,0x7F}, mask=1111, ready held 1 -> results 0x7F,0x80,0xFF,0x00 for ch0..3 in order, overrun=0.
REQ-037 Comparator model alternating vin 0x40/0x43 per conversion, osr=2 -> result 0x41 (truncated mean), four SAMPLE pulses before valid.
REQ-038 mask=0101, continuous=1, ready=0 -> overrun set at the second result; continuous dropped mid-scan -> FSM returns to IDLE after ch2.
REQ-039 rst_n low during CONVERT bit 3 -> all outputs 0 immediately. mask=0000 with start -> busy stays 0.
